// File: rtl/sm4_pkg.sv
// SM4 key-schedule constants, S-box and controller state type.
package sm4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DRAIN
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd31;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  // Byte j of CK[i] is (4i+j)*7 mod 256, most significant byte first.
  localparam logic [31:0] CK [32] = '{
    32'h00070E15, 32'h1C232A31, 32'h383F464D, 32'h545B6269,
    32'h70777E85, 32'h8C939AA1, 32'hA8AFB6BD, 32'hC4CBD2D9,
    32'hE0E7EEF5, 32'hFC030A11, 32'h181F262D, 32'h343B4249,
    32'h50575E65, 32'h6C737A81, 32'h888F969D, 32'hA4ABB2B9,
    32'hC0C7CED5, 32'hDCE3EAF1, 32'hF8FF060D, 32'h141B2229,
    32'h30373E45, 32'h4C535A61, 32'h686F767D, 32'h848B9299,
    32'hA0A7AEB5, 32'hBCC3CAD1, 32'hD8DFE6ED, 32'hF4FB0209,
    32'h10171E25, 32'h2C333A41, 32'h484F565D, 32'h646B7279
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Four independent byte substitutions.
  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

endpackage

// File: rtl/sm4_key_sched_ctrl_if.sv
// Key-load and round-key stream signals of the SM4 key-schedule controller.
interface sm4_key_sched_ctrl_if;
  logic [127:0] crypto_key;
  logic         key_expansion_run;
  logic         key_expansion_abort;
  logic         key_expansion_busy;
  logic         crypto_rnd_key_vld;
  logic         crypto_rnd_key_rdy;
  logic [31:0]  crypto_rnd_key;
  logic [4:0]   crypto_rnd_key_idx;

  // Key loader / round-key consumer side.
  modport master (
    output crypto_key, key_expansion_run, key_expansion_abort, crypto_rnd_key_rdy,
    input  key_expansion_busy, crypto_rnd_key_vld, crypto_rnd_key, crypto_rnd_key_idx
  );

  // Controller side.
  modport slave (
    input  crypto_key, key_expansion_run, key_expansion_abort, crypto_rnd_key_rdy,
    output key_expansion_busy, crypto_rnd_key_vld, crypto_rnd_key, crypto_rnd_key_idx
  );
endinterface

// File: rtl/sm4_key_round.sv
// One SM4 key-schedule round: rk = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK)).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] ck,
  output logic [31:0] rk
);

  logic [31:0] b;

  assign b  = tau(k1 ^ k2 ^ k3 ^ ck);
  // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  assign rk = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// Iterative SM4 key expansion: one round per cycle, round keys out on a valid/ready stream.
module sm4_key_sched_ctrl
  import sm4_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset_sys,
  sm4_key_sched_ctrl_if.slave  key_if
);

  state_t      state;
  logic [31:0] k [4];
  logic [4:0]  cnt;
  logic [31:0] out_key;
  logic [4:0]  out_idx;
  logic        vld;
  logic        busy;
  logic [31:0] rk;

  sm4_key_round u_round (
    .k0 (k[0]),
    .k1 (k[1]),
    .k2 (k[2]),
    .k3 (k[3]),
    .ck (CK[cnt]),
    .rk (rk)
  );

  // Controller FSM: key window, round counter and registered output slot.
  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      state   <= IDLE;
      k       <= '{default: '0};
      cnt     <= '0;
      out_key <= '0;
      out_idx <= '0;
      vld     <= 1'b0;
      busy    <= 1'b0;
    end else if (key_if.key_expansion_abort) begin
      state   <= IDLE;
      k       <= '{default: '0};
      cnt     <= '0;
      out_key <= '0;
      out_idx <= '0;
      vld     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_if.key_expansion_run) begin
            k[0]  <= key_if.crypto_key[127:96] ^ FK[0];
            k[1]  <= key_if.crypto_key[95:64]  ^ FK[1];
            k[2]  <= key_if.crypto_key[63:32]  ^ FK[2];
            k[3]  <= key_if.crypto_key[31:0]   ^ FK[3];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          // A new round only advances when the output slot is empty or being taken.
          if (!vld || key_if.crypto_rnd_key_rdy) begin
            out_key <= rk;
            out_idx <= cnt;
            vld     <= 1'b1;
            k[0]    <= k[1];
            k[1]    <= k[2];
            k[2]    <= k[3];
            k[3]    <= rk;
            cnt     <= cnt + 5'd1;
            if (cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (key_if.crypto_rnd_key_rdy) begin
            vld   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_if.key_expansion_busy = busy;
  assign key_if.crypto_rnd_key_vld = vld;
  assign key_if.crypto_rnd_key     = out_key;
  assign key_if.crypto_rnd_key_idx = out_idx;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Self-checking bench for sm4_key_sched_ctrl against a word-level SM4 key-expansion model.
module tb_sm4_key_sched_ctrl;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam int unsigned  BUDGET  = 400;

  logic clk_sys = 1'b0;
  logic reset_sys;

  sm4_key_sched_ctrl_if key_if();

  sm4_key_sched_ctrl dut (
    .clk_sys   (clk_sys),
    .reset_sys (reset_sys),
    .key_if    (key_if)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_rk [32];
  logic [31:0] obs_key [$];
  int          obs_idx [$];
  int          obs_edge [$];
  int          stall_changes;
  bit          timed_out;
  bit          aborted;
  bit          last_busy;

  logic [31:0] fk_ref [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  logic [7:0] sb [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference key expansion over the 36-word key sequence.
  task automatic model_expand(input logic [127:0] mk);
    logic [31:0] w [36];
    logic [31:0] x, t, ck;
    for (int j = 0; j < 4; j++) w[j] = mk[127 - 32 * j -: 32] ^ fk_ref[j];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
      x = w[i + 1] ^ w[i + 2] ^ w[i + 3] ^ ck;
      t = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
      w[i + 4] = w[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
      exp_rk[i] = w[i + 4];
    end
  endtask

  function automatic logic [31:0] obs_at(input int i);
    return (i < obs_key.size()) ? obs_key[i] : 32'hxxxxxxxx;
  endfunction

  function automatic int idx_at(input int i);
    return (i < obs_idx.size()) ? obs_idx[i] : -1;
  endfunction

  // Issue one run pulse at the current negedge; returns at the following negedge.
  task automatic start(input logic [127:0] mk);
    key_if.crypto_key        = mk;
    key_if.key_expansion_run = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    key_if.key_expansion_run = 1'b0;
  endtask

  // Drive rdy and record handshakes at each negedge until rk31 is taken, abort fires or budget runs out.
  task automatic capture(input int unsigned stall_pct, input bit hold_ends, input int run_at,
                         input logic [127:0] run_key, input int abort_at, input int unsigned budget);
    int unsigned cyc;
    bit          done, prev_stall, run_fired, r;
    logic [31:0] pk;
    logic [4:0]  pi;
    int          st0, st31, idx;
    obs_key.delete(); obs_idx.delete(); obs_edge.delete();
    stall_changes = 0; timed_out = 0; aborted = 0; last_busy = 0;
    cyc = 0; done = 0; prev_stall = 0; run_fired = 0; st0 = 0; st31 = 0; pk = '0; pi = '0;
    while (!done) begin
      if (cyc >= budget) begin
        timed_out = 1;
        break;
      end
      idx = int'(key_if.crypto_rnd_key_idx);
      if (prev_stall && (key_if.crypto_rnd_key_vld !== 1'b1 || key_if.crypto_rnd_key !== pk ||
                         key_if.crypto_rnd_key_idx !== pi))
        stall_changes++;
      r = ($urandom_range(99) >= stall_pct);
      if (hold_ends && key_if.crypto_rnd_key_vld && idx == 0 && st0 < 5) begin r = 0; st0++; end
      if (hold_ends && key_if.crypto_rnd_key_vld && idx == 31 && st31 < 5) begin r = 0; st31++; end
      key_if.key_expansion_run = 1'b0;
      if (run_at >= 0 && !run_fired && key_if.crypto_rnd_key_vld && idx == run_at) begin
        key_if.key_expansion_run = 1'b1;
        key_if.crypto_key        = run_key;
        run_fired = 1;
      end
      if (abort_at >= 0 && key_if.crypto_rnd_key_vld && idx == abort_at) begin
        key_if.key_expansion_abort = 1'b1;
        r = 0;
        aborted = 1;
        done = 1;
      end else if (key_if.crypto_rnd_key_vld && r) begin
        obs_key.push_back(key_if.crypto_rnd_key);
        obs_idx.push_back(idx);
        obs_edge.push_back(int'(cyc) + 1);
        if (idx == 31) begin
          done = 1;
          last_busy = key_if.key_expansion_busy;
        end
      end
      key_if.crypto_rnd_key_rdy = r;
      prev_stall = key_if.crypto_rnd_key_vld && !r;
      pk = key_if.crypto_rnd_key;
      pi = key_if.crypto_rnd_key_idx;
      @(posedge clk_sys);
      cyc++;
      @(negedge clk_sys);
    end
    key_if.key_expansion_run   = 1'b0;
    key_if.key_expansion_abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_sys                  = 1'b1;
    key_if.crypto_key          = '0;
    key_if.key_expansion_run   = 1'b0;
    key_if.key_expansion_abort = 1'b0;
    key_if.crypto_rnd_key_rdy  = 1'b0;
    #3;
    n_cmp++;
    if ({key_if.key_expansion_busy, key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key, key_if.crypto_rnd_key_idx} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b vld=%b key=%h idx=%0d, want all 0", key_if.key_expansion_busy,
               key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key, key_if.crypto_rnd_key_idx);
    end
    @(negedge clk_sys);
    reset_sys = 1'b0;
    key_if.crypto_rnd_key_rdy = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_cmp++;
    if (key_if.key_expansion_busy !== 1'b0 || key_if.crypto_rnd_key_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b vld=%b, want 0 0", key_if.key_expansion_busy, key_if.crypto_rnd_key_vld);
    end
  endtask

  task automatic test_standard();
    model_expand(STD_KEY);
    start(STD_KEY);
    n_cmp++;
    if (key_if.key_expansion_busy !== 1'b1 || key_if.crypto_rnd_key_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL std_start: got busy=%b vld=%b, want 1 0", key_if.key_expansion_busy, key_if.crypto_rnd_key_vld);
    end
    capture(0, 0, -1, '0, -1, BUDGET);
    n_cmp++;
    if (timed_out || obs_key.size() != 32) begin
      n_bad++;
      $display("FAIL std_count: got %0d keys (timeout=%0d), want 32", obs_key.size(), timed_out);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL std_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
    n_cmp++;
    if (obs_at(0) !== 32'hF12186F9 || obs_at(1) !== 32'h41662B61 || obs_at(31) !== 32'h9124A012) begin
      n_bad++;
      $display("FAIL std_vector: got %h %h %h, want f12186f9 41662b61 9124a012", obs_at(0), obs_at(1), obs_at(31));
    end
    n_cmp++;
    if (obs_edge.size() != 32 || obs_edge[0] != 2 || obs_edge[31] != 33) begin
      n_bad++;
      $display("FAIL std_timing: got first/last handshake edge %0d/%0d, want 2/33",
               (obs_edge.size() > 0) ? obs_edge[0] : -1, (obs_edge.size() == 32) ? obs_edge[31] : -1);
    end
    n_cmp++;
    if (key_if.key_expansion_busy !== 1'b0 || key_if.crypto_rnd_key_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL std_end: got busy=%b vld=%b, want 0 0", key_if.key_expansion_busy, key_if.crypto_rnd_key_vld);
    end
  endtask

  task automatic test_backpressure();
    model_expand(STD_KEY);
    start(STD_KEY);
    capture(40, 1, -1, '0, -1, BUDGET);
    n_cmp++;
    if (timed_out || stall_changes != 0) begin
      n_bad++;
      $display("FAIL bp_stall_stable: got %0d changes while stalled (timeout=%0d), want 0", stall_changes, timed_out);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL bp_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
    n_cmp++;
    if (obs_key.size() != 32) begin
      n_bad++;
      $display("FAIL bp_count: got %0d keys, want 32", obs_key.size());
    end
  endtask

  task automatic test_run_while_busy();
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    model_expand(k1);
    start(k1);
    capture(25, 0, 10, k2, -1, BUDGET);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL rwb_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (key_if.key_expansion_busy !== 1'b0 || key_if.crypto_rnd_key_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL rwb_no_restart[%0d]: got busy=%b vld=%b, want 0 0", c, key_if.key_expansion_busy,
                 key_if.crypto_rnd_key_vld);
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic test_abort();
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(k1);
    capture(30, 0, -1, '0, 15, BUDGET);
    n_cmp++;
    if (!aborted || {key_if.key_expansion_busy, key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key,
                     key_if.crypto_rnd_key_idx} !== 39'd0) begin
      n_bad++;
      $display("FAIL abort_clear: got busy=%b vld=%b key=%h idx=%0d (reached=%0d), want all 0",
               key_if.key_expansion_busy, key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key,
               key_if.crypto_rnd_key_idx, aborted);
    end
    key_if.crypto_key          = k2;
    key_if.key_expansion_run   = 1'b1;
    key_if.key_expansion_abort = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    key_if.key_expansion_run   = 1'b0;
    key_if.key_expansion_abort = 1'b0;
    repeat (2) begin
      n_cmp++;
      if (key_if.key_expansion_busy !== 1'b0 || key_if.crypto_rnd_key_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_beats_run: got busy=%b vld=%b, want 0 0", key_if.key_expansion_busy,
                 key_if.crypto_rnd_key_vld);
      end
      @(negedge clk_sys);
    end
    model_expand(k2);
    start(k2);
    capture(20, 0, -1, '0, -1, BUDGET);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL abort_next_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] k1;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    key_if.crypto_rnd_key_rdy = 1'b1;
    start(k1);
    repeat (5) @(posedge clk_sys);
    #2;
    n_cmp++;
    if (key_if.key_expansion_busy !== 1'b1 || key_if.crypto_rnd_key_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre: got busy=%b vld=%b, want 1 1", key_if.key_expansion_busy, key_if.crypto_rnd_key_vld);
    end
    reset_sys = 1'b1;
    #1;
    n_cmp++;
    if ({key_if.key_expansion_busy, key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key, key_if.crypto_rnd_key_idx} !== 39'd0) begin
      n_bad++;
      $display("FAIL arst_clear: got busy=%b vld=%b key=%h idx=%0d, want all 0", key_if.key_expansion_busy,
               key_if.crypto_rnd_key_vld, key_if.crypto_rnd_key, key_if.crypto_rnd_key_idx);
    end
    @(negedge clk_sys);
    reset_sys = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      n_cmp++;
      if (key_if.key_expansion_busy !== 1'b0 || key_if.crypto_rnd_key_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL arst_idle[%0d]: got busy=%b vld=%b, want 0 0", c, key_if.key_expansion_busy,
                 key_if.crypto_rnd_key_vld);
      end
    end
    model_expand(k1);
    start(k1);
    capture(15, 0, -1, '0, -1, BUDGET);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL arst_after_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k2;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(STD_KEY);
    capture(0, 0, -1, '0, -1, BUDGET);
    n_cmp++;
    if (last_busy !== 1'b1 || key_if.key_expansion_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy_fall: got busy %b at last handshake, %b after, want 1 then 0", last_busy,
               key_if.key_expansion_busy);
    end
    model_expand(k2);
    start(k2);
    n_cmp++;
    if (key_if.key_expansion_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_gap: got busy=%b one cycle after the idle gap, want 1", key_if.key_expansion_busy);
    end
    capture(10, 0, -1, '0, -1, BUDGET);
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
        n_bad++;
        $display("FAIL b2b_rk[%0d]: got %h idx %0d, want %h idx %0d", i, obs_at(i), idx_at(i), exp_rk[i], i);
      end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      start(k);
      capture(30, n[0], -1, '0, -1, BUDGET);
      n_cmp++;
      if (timed_out || stall_changes != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_stall: got %0d changes while stalled (timeout=%0d), want 0", n, stall_changes, timed_out);
      end
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (obs_at(i) !== exp_rk[i] || idx_at(i) != i) begin
          n_bad++;
          $display("FAIL rnd%0d_rk[%0d]: got %h idx %0d, want %h idx %0d", n, i, obs_at(i), idx_at(i), exp_rk[i], i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_backpressure();
    test_run_while_busy();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
